// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache: 8 lines x 4 words of 32 bits.
// A miss stalls the processor, writes back a dirty victim (WRITEBACK), refills
// the line (ALLOCATE), then re-evaluates the held request as a hit in IDLE.
// Optional macro DM_CACHE_STATS_EN adds saturating hit_cnt/miss_cnt outputs.
module dm_cache (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         proc_read,
    input  logic         proc_write,
    input  logic [29:0]  proc_addr,
    input  logic [31:0]  proc_wdata,
    output logic         proc_stall,
    output logic [31:0]  proc_rdata,
    output logic         mem_read,
    output logic         mem_write,
    output logic [27:0]  mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ready
`ifdef DM_CACHE_STATS_EN
    ,
    output logic [15:0]  hit_cnt,
    output logic [15:0]  miss_cnt
`endif
);

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned LINE_W    = 128;
    localparam int unsigned NUM_LINES = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned OFF_W     = 2;
    localparam int unsigned TAG_W     = 25;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [TAG_W-1:0]       tag_q  [NUM_LINES];
    logic [LINE_W-1:0]      data_q [NUM_LINES];

    logic                   req;
    logic [OFF_W-1:0]       off;
    logic [IDX_W-1:0]       idx;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   idle_hit;
    logic                   idle_miss;
    logic [LINE_W-1:0]      line;

    // Address split and hit detection for the current request
    always_comb begin
        req       = proc_read | proc_write;
        off       = proc_addr[1:0];
        idx       = proc_addr[4:2];
        tag       = proc_addr[29:5];
        line      = data_q[idx];
        hit       = req & valid_q[idx] & (tag_q[idx] == tag);
        idle_hit  = (state_q == ST_IDLE) & hit;
        idle_miss = (state_q == ST_IDLE) & req & ~hit;
    end

    // Processor and memory side outputs decoded from the current state
    always_comb begin
        proc_stall = 1'b0;
        proc_rdata = line[{off, 5'b00000} +: WORD_W];
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = proc_addr[29:2];
        mem_wdata  = line;
        case (state_q)
            ST_IDLE: begin
                proc_stall = idle_miss;
            end
            ST_WRITEBACK: begin
                proc_stall = 1'b1;
                mem_write  = 1'b1;
                mem_addr   = {tag_q[idx], idx};
            end
            ST_ALLOCATE: begin
                proc_stall = 1'b1;
                mem_read   = 1'b1;
            end
            default: begin
                proc_stall = 1'b0;
            end
        endcase
    end

    // Controller state and per-line valid/dirty bits; reset abandons any transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (idle_hit && proc_write) begin
                        dirty_q[idx] <= 1'b1;
                    end else if (idle_miss) begin
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q <= ST_WRITEBACK;
                        end else begin
                            state_q <= ST_ALLOCATE;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        state_q <= ST_ALLOCATE;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) begin
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays: refill on allocate completion, word merge on write hit
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if ((state_q == ST_ALLOCATE) && mem_ready) begin
                tag_q[idx]  <= tag;
                data_q[idx] <= mem_rdata;
            end else if (idle_hit && proc_write) begin
                data_q[idx][{off, 5'b00000} +: WORD_W] <= proc_wdata;
            end
        end
    end

`ifdef DM_CACHE_STATS_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating hit/miss counters; a post-refill hit counts as a hit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (idle_hit && (hit_cnt_q != 16'hFFFF)) begin
                hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (idle_miss && (miss_cnt_q != 16'hFFFF)) begin
                miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dm_cache.sv
// Self-checking bench for dm_cache: directed miss/hit/writeback/reset scenarios,
// a random access phase against a flat word-memory shadow, and (with
// DM_CACHE_STATS_EN) the hit/miss counters.
module tb_dm_cache;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         proc_read;
    logic         proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;
`ifdef DM_CACHE_STATS_EN
    logic [15:0]  hit_cnt;
    logic [15:0]  miss_cnt;
`endif

    always #5 clk = ~clk;

    dm_cache dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .proc_read  (proc_read),
        .proc_write (proc_write),
        .proc_addr  (proc_addr),
        .proc_wdata (proc_wdata),
        .proc_stall (proc_stall),
        .proc_rdata (proc_rdata),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
`ifdef DM_CACHE_STATS_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    typedef struct {
        bit           wr;
        logic [27:0]  addr;
        logic [127:0] data;
    } txn_t;

    txn_t         log_q[$];
    logic [31:0]  exp_q[$];
    logic [127:0] mem_blk [logic [27:0]];
    logic [31:0]  shadow  [logic [29:0]];
    int           n_chk = 0;
    int           n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [29:0] a);
        return 32'h5A5A_0000 ^ {2'b00, a} ^ {a[7:0], 24'h000000};
    endfunction

    function automatic logic [31:0] get_word(input logic [29:0] a);
        if (shadow.exists(a)) return shadow[a];
        return init_word(a);
    endfunction

    function automatic logic [127:0] blk_get(input logic [27:0] b);
        if (mem_blk.exists(b)) return mem_blk[b];
        return {init_word({b, 2'd3}), init_word({b, 2'd2}),
                init_word({b, 2'd1}), init_word({b, 2'd0})};
    endfunction

    // One processor access held until unstalled; serves memory with 2-cycle latency
    task automatic access(input bit rd, input bit wr, input logic [29:0] a,
                          input logic [31:0] wd, output int stalled);
        int  lat;
        bit  done;
        @(negedge clk);
        proc_read  = rd;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = wd;
        if (wr) shadow[a] = wd;
        else    exp_q.push_back(get_word(a));
        stalled = 0;
        lat     = 0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            check("mem_excl", 128'(mem_read & mem_write), 128'd0);
            if (!proc_stall) begin
                if (!wr) check("rdata", 128'(proc_rdata), 128'(exp_q.pop_front()));
                done = 1'b1;
            end else begin
                stalled++;
                if (mem_read || mem_write) begin
                    lat++;
                    if (lat == 2) begin
                        lat = 0;
                        log_q.push_back('{mem_write, mem_addr, mem_wdata});
                        if (mem_write) mem_blk[mem_addr] = mem_wdata;
                        else           mem_rdata = blk_get(mem_addr);
                        mem_ready = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1 mem_ready = 1'b0;
            if (!done) @(negedge clk);
        end
        if (!done) begin
            check("timeout", 128'd0, 128'd1);
            if (!wr && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        proc_read  = 1'b0;
        proc_write = 1'b0;
    endtask

    task automatic check_txn(input string tag, input int i, input bit wr, input logic [27:0] addr);
        if (i < log_q.size()) begin
            check({tag, "_kind"}, 128'(log_q[i].wr), 128'(wr));
            check({tag, "_addr"}, 128'(log_q[i].addr), 128'(addr));
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        mem_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int st;
        logic [29:0] ra;
        int kind;

        proc_addr  = '0;
        proc_wdata = '0;
        mem_rdata  = '0;
        do_reset();

        // Reset state with no request
        @(negedge clk); #1;
        check("rst_stall", 128'(proc_stall), 128'd0);
        check("rst_mem_read", 128'(mem_read), 128'd0);
        check("rst_mem_write", 128'(mem_write), 128'd0);

        // Cold read miss: one IDLE miss cycle plus two ALLOCATE cycles
        log_q.delete();
        access(1'b1, 1'b0, 30'h10, 32'h0, st);
        check("cold_stall_cycles", 128'(st), 128'd3);
        check("cold_ntxn", 128'(log_q.size()), 128'd1);
        check_txn("cold_alloc", 0, 1'b0, 28'h4);

        // Write hit then read hit, no memory traffic
        log_q.delete();
        access(1'b0, 1'b1, 30'h11, 32'hDEADBEEF, st);
        check("wrhit_stall", 128'(st), 128'd0);
        access(1'b1, 1'b0, 30'h11, 32'h0, st);
        check("rdhit_stall", 128'(st), 128'd0);
        check("hit_ntxn", 128'(log_q.size()), 128'd0);

        // Conflict miss on dirty line: writeback of old line then refill
        log_q.delete();
        access(1'b1, 1'b0, 30'h31, 32'h0, st);
        check("evict_stall_cycles", 128'(st), 128'd5);
        check("evict_ntxn", 128'(log_q.size()), 128'd2);
        check_txn("evict_wb", 0, 1'b1, 28'h4);
        check_txn("evict_alloc", 1, 1'b0, 28'hC);
        if (log_q.size() > 0) begin
            check("evict_word1", 128'(log_q[0].data[63:32]), 128'(32'hDEADBEEF));
            check("evict_block", log_q[0].data,
                  {get_word(30'h13), get_word(30'h12), get_word(30'h11), get_word(30'h10)});
        end

        // Write miss to a clean (invalid) line: allocate only, merge, dirty
        log_q.delete();
        access(1'b0, 1'b1, 30'h40, 32'h12345678, st);
        check("wrmiss_stall_cycles", 128'(st), 128'd3);
        check("wrmiss_ntxn", 128'(log_q.size()), 128'd1);
        check_txn("wrmiss_alloc", 0, 1'b0, 28'h10);
        access(1'b1, 1'b0, 30'h40, 32'h0, st);
        check("wrmiss_readback_stall", 128'(st), 128'd0);
        log_q.delete();
        access(1'b1, 1'b0, 30'h60, 32'h0, st);
        check("wrmiss_dirty_ntxn", 128'(log_q.size()), 128'd2);
        check_txn("wrmiss_dirty_wb", 0, 1'b1, 28'h10);
        if (log_q.size() > 0)
            check("wrmiss_dirty_word0", 128'(log_q[0].data[31:0]), 128'(32'h12345678));
        check_txn("wrmiss_dirty_alloc", 1, 1'b0, 28'h18);

        // Reset in the middle of ALLOCATE, then a late mem_ready pulse
        @(negedge clk);
        proc_read = 1'b1;
        proc_addr = 30'h80;
        #1 check("ra_stall", 128'(proc_stall), 128'd1);
        @(negedge clk);
        #1 check("ra_mem_read", 128'(mem_read), 128'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        proc_read = 1'b0;
        mem_rdata = {4{32'hBADBAD00}};
        mem_ready = 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        @(negedge clk); #1;
        check("ra_idle_stall", 128'(proc_stall), 128'd0);
        check("ra_idle_mem_read", 128'(mem_read), 128'd0);
        check("ra_idle_mem_write", 128'(mem_write), 128'd0);
        log_q.delete();
        access(1'b1, 1'b0, 30'h31, 32'h0, st);
        check("ra_inv4_stall_cycles", 128'(st), 128'd3);
        check("ra_inv4_ntxn", 128'(log_q.size()), 128'd1);
        check_txn("ra_inv4_alloc", 0, 1'b0, 28'hC);
        log_q.delete();
        access(1'b1, 1'b0, 30'h60, 32'h0, st);
        check("ra_inv0_stall_cycles", 128'(st), 128'd3);
        access(1'b1, 1'b0, 30'h80, 32'h0, st);

        // Random mixed traffic over 4 tags on every index
        for (int n = 0; n < 80; n++) begin
            ra   = {25'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 2'($urandom_range(3, 0))};
            kind = $urandom_range(2, 0);
            access(kind != 1, kind != 0, ra, $urandom(), st);
        end
        @(negedge clk); #1;
        check("quiet_stall", 128'(proc_stall), 128'd0);

`ifdef DM_CACHE_STATS_EN
        // Counters: one cold miss plus three hits (post-refill hit counts too)
        do_reset();
        shadow.delete();
        mem_blk.delete();
        @(negedge clk); #1;
        check("stats_rst_hit", 128'(hit_cnt), 128'd0);
        check("stats_rst_miss", 128'(miss_cnt), 128'd0);
        access(1'b1, 1'b0, 30'h100, 32'h0, st);
        access(1'b1, 1'b0, 30'h101, 32'h0, st);
        access(1'b1, 1'b0, 30'h102, 32'h0, st);
        access(1'b0, 1'b1, 30'h103, 32'hCAFEF00D, st);
        @(negedge clk); #1;
        check("stats_miss", 128'(miss_cnt), 128'd1);
        check("stats_hit", 128'(hit_cnt), 128'd4);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
